// File: rtl/frv_mem_responder_pkg.sv
// Shared definitions for the frv memory responder: stall-mode encodings,
// LFSR feedback mask, FSM state type and the stall-draw helper.
package frv_mem_responder_pkg;

  localparam int unsigned STALL_NONE   = 0;
  localparam int unsigned STALL_FIXED  = 1;
  localparam int unsigned STALL_RANDOM = 2;

  // Galois right-shift mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    ST_IDLE,
    ST_STALL
  } state_e;

  // Number of wait-states to insert for a request starting this cycle.
  function automatic logic [3:0] stall_draw(input int unsigned mode,
                                            input logic [3:0]  nib,
                                            input logic [3:0]  lim);
    logic [3:0] d;
    d = '0;
    case (mode)
      STALL_FIXED:  d = lim;
      STALL_RANDOM: d = (nib < lim) ? nib : lim;
      default:      d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/frv_mem_responder_if.sv
// frv req/gnt memory bus.
//   mem_req/mem_wen/mem_strb/mem_wdata/mem_addr : core -> memory
//   mem_gnt/mem_error/mem_rdata                 : memory -> core
// master = core side, slave = memory responder side.
interface frv_mem_responder_if;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_strb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_error;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wen, mem_strb, mem_wdata, mem_addr,
    input  mem_gnt, mem_error, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wen, mem_strb, mem_wdata, mem_addr,
    output mem_gnt, mem_error, mem_rdata
  );
endinterface

// File: rtl/frv_mem_responder_lfsr16.sv
// Seeded 16-bit Galois LFSR with enable and synchronous reset.
//   clk   : clock
//   rst   : synchronous reset, loads SEED
//   en    : advance one step this cycle
//   state : current LFSR value
module frv_lfsr16
  import frv_mem_responder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/frv_mem_responder.sv
// Memory responder for one frv imem/dmem port, backed by a word-addressed
// single-port RAM with synchronous read and optional wait-state injection.
//   g_clk        : global clock
//   g_reset      : synchronous reset, active high
//   mem          : frv req/gnt bus, responder side
//   protocol_err : sticky flag, request dropped while stalled
module frv_mem_responder
  import frv_mem_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE     = 32'h8000_0000,
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned READ_ONLY    = 0,
  parameter int unsigned STALL_MODE   = 0,
  parameter int unsigned STALL_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 g_clk,
  input  logic                 g_reset,
  frv_mem_responder_if.slave   mem,
  output logic                 protocol_err
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  STALL_LIM = 4'(STALL_CYCLES);

  state_e      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic [3:0]  draw;
  logic        gnt;
  logic        perr_set;
  logic [15:0] lfsr;
  logic        lfsr_unused;

  logic [31:0]   off;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [31:0]   ram [MEM_WORDS];

  frv_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (g_clk),
    .rst   (g_reset),
    .en    (1'b1),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:4];
  assign draw        = stall_draw(STALL_MODE, lfsr[3:0], STALL_LIM);

  // Offset wraps modulo 2^32, so addresses below MEM_BASE land far out of range.
  assign off     = mem.mem_addr - MEM_BASE;
  assign acc_err = (off >= MEM_BYTES) || (mem.mem_wen && (READ_ONLY != 0));
  assign idx     = off[AW+1:2];

  assign mem.mem_gnt = gnt;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    gnt        = 1'b0;
    perr_set   = 1'b0;
    if (!g_reset) begin
      case (state)
        ST_IDLE: begin
          if (mem.mem_req) begin
            if (draw == '0) begin
              gnt = 1'b1;
            end else begin
              cnt_next   = draw - 4'd1;
              state_next = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (!mem.mem_req) begin
            perr_set   = 1'b1;
            state_next = ST_IDLE;
          end else if (cnt == '0) begin
            gnt        = 1'b1;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (perr_set) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge g_clk) begin
    if (gnt && mem.mem_wen && !acc_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mem.mem_strb[i]) begin
          ram[idx][8*i +: 8] <= mem.mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      mem.mem_error <= 1'b0;
      mem.mem_rdata <= '0;
    end else if (gnt) begin
      mem.mem_error <= acc_err;
      mem.mem_rdata <= (acc_err || mem.mem_wen) ? '0 : ram[idx];
    end
  end

endmodule

// File: tb/tb_frv_mem_responder.sv
// Scoreboard bench for frv_mem_responder. Four instances cover zero-wait,
// fixed-stall, random-stall and read-only configurations.
module tb_frv_mem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic g_clk = 1'b0;
  logic g_reset = 1'b1;
  always #5 g_clk = ~g_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  logic        req_v   [4];
  logic        wen_v   [4];
  logic [3:0]  strb_v  [4];
  logic [31:0] wdata_v [4];
  logic [31:0] addr_v  [4];
  logic [3:0]  gnt_v, err_v, perr_v;
  logic [31:0] rd_v [4];

  frv_mem_responder_if ifa ();
  frv_mem_responder_if ifb ();
  frv_mem_responder_if ifc ();
  frv_mem_responder_if ifd ();

  assign ifa.mem_req = req_v[0]; assign ifa.mem_wen = wen_v[0]; assign ifa.mem_strb = strb_v[0];
  assign ifa.mem_wdata = wdata_v[0]; assign ifa.mem_addr = addr_v[0];
  assign ifb.mem_req = req_v[1]; assign ifb.mem_wen = wen_v[1]; assign ifb.mem_strb = strb_v[1];
  assign ifb.mem_wdata = wdata_v[1]; assign ifb.mem_addr = addr_v[1];
  assign ifc.mem_req = req_v[2]; assign ifc.mem_wen = wen_v[2]; assign ifc.mem_strb = strb_v[2];
  assign ifc.mem_wdata = wdata_v[2]; assign ifc.mem_addr = addr_v[2];
  assign ifd.mem_req = req_v[3]; assign ifd.mem_wen = wen_v[3]; assign ifd.mem_strb = strb_v[3];
  assign ifd.mem_wdata = wdata_v[3]; assign ifd.mem_addr = addr_v[3];

  assign gnt_v = {ifd.mem_gnt, ifc.mem_gnt, ifb.mem_gnt, ifa.mem_gnt};
  assign err_v = {ifd.mem_error, ifc.mem_error, ifb.mem_error, ifa.mem_error};
  assign rd_v[0] = ifa.mem_rdata;
  assign rd_v[1] = ifb.mem_rdata;
  assign rd_v[2] = ifc.mem_rdata;
  assign rd_v[3] = ifd.mem_rdata;

  frv_mem_responder #(.MEM_WORDS(4096), .STALL_MODE(0)) u_a (
    .g_clk(g_clk), .g_reset(g_reset), .mem(ifa.slave), .protocol_err(perr_v[0]));
  frv_mem_responder #(.MEM_WORDS(256), .STALL_MODE(1), .STALL_CYCLES(3)) u_b (
    .g_clk(g_clk), .g_reset(g_reset), .mem(ifb.slave), .protocol_err(perr_v[1]));
  frv_mem_responder #(.MEM_WORDS(16), .STALL_MODE(2), .STALL_CYCLES(6)) u_c (
    .g_clk(g_clk), .g_reset(g_reset), .mem(ifc.slave), .protocol_err(perr_v[2]));
  frv_mem_responder #(.MEM_WORDS(256), .READ_ONLY(1), .STALL_MODE(0)) u_d (
    .g_clk(g_clk), .g_reset(g_reset), .mem(ifd.slave), .protocol_err(perr_v[3]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: a response is due the cycle after each gnt.
  bit seen [4];
  always @(negedge g_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (g_reset) begin
        seen[i] = 1'b0;
      end else begin
        if (seen[i]) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp inst%0d: got err=%b rdata=%h expected none", i, err_v[i], rd_v[i]);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.inst != i || err_v[i] !== e.err || rd_v[i] !== e.rdata) begin
              bad++;
              $display("FAIL resp inst%0d: got err=%b rdata=%h expected inst%0d err=%b rdata=%h",
                       i, err_v[i], rd_v[i], e.inst, e.err, e.rdata);
            end
          end
        end
        seen[i] = gnt_v[i];
      end
    end
  end

  // Issue one access, push its expected response, wait (bounded) for gnt.
  task automatic access(input int s, input logic w, input logic [31:0] a,
                        input logic [3:0] st, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_rd,
                        input int lmin, input int lmax, output int lat);
    exp_t e;
    bit ok;
    req_v[s] = 1'b1; wen_v[s] = w; addr_v[s] = a; strb_v[s] = st; wdata_v[s] = wd;
    e.inst = s; e.err = e_err; e.rdata = e_rd;
    exp_q.push_back(e);
    lat = 0; ok = 1'b0;
    while (lat <= 40) begin
      @(negedge g_clk);
      if (gnt_v[s]) begin ok = 1'b1; break; end
      lat++;
      @(posedge g_clk); #1;
    end
    total++;
    if (!ok || lat < lmin || lat > lmax) begin
      bad++;
      $display("FAIL latency inst%0d addr %h: got %0d (gnt=%b) expected %0d..%0d", s, a, lat, ok, lmin, lmax);
    end
    @(posedge g_clk); #1;
    req_v[s] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge g_clk); #1;
    end
  endtask

  logic [31:0] mdl [16];
  int lat, maxlat;

  initial begin
    for (int i = 0; i < 4; i++) begin
      req_v[i] = 1'b0; wen_v[i] = 1'b0; strb_v[i] = '0; wdata_v[i] = '0; addr_v[i] = '0;
    end
    idle(3);
    @(negedge g_clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset_gnt%0d", i), {31'd0, gnt_v[i]}, 32'd0);
      chk($sformatf("reset_err%0d", i), {31'd0, err_v[i]}, 32'd0);
      chk($sformatf("reset_rdata%0d", i), rd_v[i], 32'd0);
      chk($sformatf("reset_perr%0d", i), {31'd0, perr_v[i]}, 32'd0);
    end
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    idle(1);

    // Zero-wait instance: full write, partial write, no-op write, boundaries.
    access(0, 1'b1, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 0, lat);
    access(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0,        1'b0, 32'hDEAD_BEEF, 0, 0, lat);
    access(0, 1'b1, 32'h8000_0012, 4'b0010, 32'h0000_5500, 1'b0, 32'h0, 0, 0, lat);
    access(0, 1'b0, 32'h8000_0011, 4'h0, 32'h0,        1'b0, 32'hDEAD_55EF, 0, 0, lat);
    access(0, 1'b1, 32'h8000_0010, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0, 0, 0, lat);
    access(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0,        1'b0, 32'hDEAD_55EF, 0, 0, lat);
    access(0, 1'b1, 32'h8000_3FFC, 4'hF, 32'h0BAD_F00D, 1'b0, 32'h0, 0, 0, lat);
    access(0, 1'b0, 32'h8000_3FFC, 4'h0, 32'h0,        1'b0, 32'h0BAD_F00D, 0, 0, lat);
    access(0, 1'b0, 32'h8000_4000, 4'h0, 32'h0,        1'b1, 32'h0, 0, 0, lat);
    access(0, 1'b0, 32'h8000_0010, 4'h0, 32'h0,        1'b0, 32'hDEAD_55EF, 0, 0, lat);
    access(0, 1'b0, 32'h7FFF_FFFC, 4'h0, 32'h0,        1'b1, 32'h0, 0, 0, lat);
    access(0, 1'b1, 32'h8000_4000, 4'hF, 32'h1234_5678, 1'b1, 32'h0, 0, 0, lat);
    idle(2);

    // Read-only instance: writes always error.
    access(3, 1'b1, 32'h8000_0000, 4'hF, 32'hCAFE_F00D, 1'b1, 32'h0, 0, 0, lat);
    access(3, 1'b0, 32'h8000_0400, 4'h0, 32'h0,        1'b1, 32'h0, 0, 0, lat);
    access(3, 1'b1, 32'h8000_0004, 4'h0, 32'h0,        1'b1, 32'h0, 0, 0, lat);
    idle(2);

    // Fixed stall of 3.
    access(1, 1'b1, 32'h8000_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0, 3, 3, lat);
    access(1, 1'b0, 32'h8000_0020, 4'h0, 32'h0,        1'b0, 32'h1122_3344, 3, 3, lat);
    idle(2);

    // Drop req while stalled.
    req_v[1] = 1'b1; wen_v[1] = 1'b0; addr_v[1] = 32'h8000_0020;
    @(posedge g_clk); #1;
    req_v[1] = 1'b0;
    @(negedge g_clk);
    chk("drop_no_gnt", {31'd0, gnt_v[1]}, 32'd0);
    @(posedge g_clk); #1;
    chk("perr_set", {31'd0, perr_v[1]}, 32'd1);
    idle(5);
    chk("perr_sticky", {31'd0, perr_v[1]}, 32'd1);
    chk("perr_other", {31'd0, perr_v[0]}, 32'd0);

    // Reset while a write is stalled: the write must not land.
    req_v[1] = 1'b1; wen_v[1] = 1'b1; strb_v[1] = 4'hF; wdata_v[1] = 32'hAAAA_AAAA;
    addr_v[1] = 32'h8000_0020;
    idle(2);
    g_reset = 1'b1; req_v[1] = 1'b0;
    idle(1);
    g_reset = 1'b0;
    chk("perr_cleared", {31'd0, perr_v[1]}, 32'd0);
    access(1, 1'b0, 32'h8000_0020, 4'h0, 32'h0, 1'b0, 32'h1122_3344, 3, 3, lat);
    idle(2);

    // Random stalls, back-to-back traffic against a word model.
    maxlat = 0;
    for (int w = 0; w < 16; w++) begin
      mdl[w] = $urandom;
      access(2, 1'b1, BASE + 32'(w * 4), 4'hF, mdl[w], 1'b0, 32'h0, 0, 6, lat);
      if (lat > maxlat) maxlat = lat;
    end
    for (int k = 0; k < 3000; k++) begin
      logic        w, oor;
      logic [3:0]  st, wi;
      logic [31:0] a, wd, er;
      w   = 1'($urandom_range(0, 1));
      st  = 4'($urandom_range(0, 15));
      wd  = $urandom;
      wi  = 4'($urandom_range(0, 15));
      oor = ($urandom_range(0, 7) == 0);
      if (oor) a = ($urandom_range(0, 1) == 0) ? (BASE + 32'h40 + 32'(wi) * 4) : (BASE - 32'h4);
      else     a = BASE + 32'(wi) * 4;
      a = a + 32'($urandom_range(0, 3));
      er = (oor || w) ? 32'h0 : mdl[wi];
      if (w && !oor) begin
        for (int b = 0; b < 4; b++) begin
          if (st[b]) mdl[wi][8*b +: 8] = wd[8*b +: 8];
        end
      end
      access(2, w, a, st, wd, oor, er, 0, 6, lat);
      if (lat > maxlat) maxlat = lat;
      if ($urandom_range(0, 15) == 0) idle(1);
    end
    idle(3);
    chk("random_stall_seen", {31'd0, maxlat > 0}, 32'd1);
    chk("pending_resp", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
